// File: rtl/bsg_upstream_pkg.sv
// Shared types and constants for the upstream output scheduler.
package bsg_upstream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int BEATS_PER_WORD = 4;
    localparam int CH_W           = 8;
    localparam int WORD_W         = 64;

endpackage

// File: rtl/bsg_upstream_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// after the pointer, searching upward with wrap-around.
module bsg_upstream_rr_arb #(
    parameter int NUM_SRC = 4,
    parameter int PTR_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_SRC-1:0] grant_o
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_SRC; off++) begin
            idx = (int'(ptr_i) + off) % NUM_SRC;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_upstream_out_sched.sv
// Credit-gated round-robin scheduler that serialises 64-bit core words as four
// 16-bit beats across two 8-bit upstream link channels.
module bsg_upstream_out_sched
    import bsg_upstream_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CREDITS = 8,
    parameter int CRED_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        core_valid_in,
    input  logic [NUM_SRC*WORD_W-1:0] core_data_in,
    output logic [NUM_SRC-1:0]        core_ready_out,
    input  logic                      io_token,
    output logic                      io_valid_out,
    output logic [CH_W-1:0]           io_data_out_ch0,
    output logic [CH_W-1:0]           io_data_out_ch1,
    output logic [CRED_W-1:0]         credits,
    output logic [6:0]                sent_cnt,
    output logic [6:0]                finish_cnt,
    output logic                      token_err
);

    localparam int PTR_W = $clog2(NUM_SRC);

    state_e              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CRED_W-1:0]   credits_q, credits_d;
    logic [6:0]          sent_q, sent_d;
    logic [6:0]          fin_q, fin_d;
    logic                err_q, err_d;

    logic [NUM_SRC-1:0]  grant;
    logic [NUM_SRC-1:0]  ready;
    logic                xfer;
    logic [PTR_W-1:0]    gidx;
    logic [WORD_W-1:0]   sel_word;

    bsg_upstream_rr_arb #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i   (core_valid_in),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Grant is one-hot, so OR-ing masked words and indices yields the winner.
    always_comb begin
        gidx     = '0;
        sel_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                gidx = PTR_W'(i);
            end
            sel_word = sel_word | ({WORD_W{grant[i]}} & core_data_in[WORD_W*i +: WORD_W]);
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        data_d    = data_q;
        ptr_d     = ptr_q;
        credits_d = credits_q;
        sent_d    = sent_q;
        fin_d     = fin_q;
        err_d     = err_q;
        ready     = '0;
        xfer      = 1'b0;

        case (state_q)
            IDLE: begin
                if (credits_q != '0) begin
                    ready = grant;
                end
                xfer = |ready;
                if (xfer) begin
                    data_d  = sel_word;
                    beat_d  = 2'd0;
                    ptr_d   = (gidx == PTR_W'(NUM_SRC-1)) ? '0 : gidx + PTR_W'(1);
                    state_d = SEND;
                end
            end
            SEND: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'(BEATS_PER_WORD-1)) begin
                    sent_d  = sent_q + 7'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A token coinciding with a transfer cancels the decrement.
        if (io_token) begin
            fin_d = fin_q + 7'd1;
            if (credits_q == CRED_W'(CREDITS)) begin
                err_d = 1'b1;
            end
            if (!xfer && credits_q != CRED_W'(CREDITS)) begin
                credits_d = credits_q + CRED_W'(1);
            end
        end else if (xfer) begin
            credits_d = credits_q - CRED_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= 2'd0;
            data_q    <= '0;
            ptr_q     <= '0;
            credits_q <= CRED_W'(CREDITS);
            sent_q    <= '0;
            fin_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            sent_q    <= sent_d;
            fin_q     <= fin_d;
            err_q     <= err_d;
        end
    end

    // Ready is masked by reset so it drops together with the registered outputs.
    assign core_ready_out  = ready & {NUM_SRC{rst_n}};
    assign io_valid_out    = (state_q == SEND);
    assign io_data_out_ch0 = (state_q == SEND) ? data_q[{beat_q, 4'd0} +: CH_W]     : '0;
    assign io_data_out_ch1 = (state_q == SEND) ? data_q[{beat_q, 4'd8} +: CH_W]     : '0;
    assign credits         = credits_q;
    assign sent_cnt        = sent_q;
    assign finish_cnt      = fin_q;
    assign token_err       = err_q;

endmodule

// File: tb/tb_bsg_upstream_out_sched.sv
// Directed bench: cycle table for serialisation/arbitration, hand sequences for
// credit, token and asynchronous-reset corner cases.
module tb_bsg_upstream_out_sched;

    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'h7766_5544_3322_1100;
    localparam logic [63:0] D2 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D3 = 64'hDEAD_BEEF_CAFE_F00D;

    logic         clk;
    logic         rst_n;
    logic [255:0] data_bus;
    logic [3:0]   valid_a, valid_b;
    logic         tok_a, tok_b;

    logic [3:0]   ready_a, ready_b;
    logic         v_a, v_b;
    logic [7:0]   c0_a, c1_a, c0_b, c1_b;
    logic [3:0]   cred_a, cred_b;
    logic [6:0]   sent_a, sent_b, fin_a, fin_b;
    logic         err_a, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    bsg_upstream_out_sched #(.NUM_SRC(4), .CREDITS(8), .CRED_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .core_valid_in(valid_a), .core_data_in(data_bus),
        .core_ready_out(ready_a), .io_token(tok_a), .io_valid_out(v_a),
        .io_data_out_ch0(c0_a), .io_data_out_ch1(c1_a), .credits(cred_a),
        .sent_cnt(sent_a), .finish_cnt(fin_a), .token_err(err_a)
    );

    bsg_upstream_out_sched #(.NUM_SRC(4), .CREDITS(2), .CRED_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .core_valid_in(valid_b), .core_data_in(data_bus),
        .core_ready_out(ready_b), .io_token(tok_b), .io_valid_out(v_b),
        .io_data_out_ch0(c0_b), .io_data_out_ch1(c1_b), .credits(cred_b),
        .sent_cnt(sent_b), .finish_cnt(fin_b), .token_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] ready;
        logic       v;
        logic [7:0] ch0;
        logic [7:0] ch1;
        logic [3:0] cred;
        logic [6:0] sent;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(logic rst, logic [3:0] va, logic [3:0] rdy, logic v,
                                logic [7:0] c0, logic [7:0] c1, logic [3:0] cr, logic [6:0] s);
        vec_t r;
        r.rst = rst; r.valid = va; r.ready = rdy; r.v = v;
        r.ch0 = c0; r.ch1 = c1; r.cred = cr; r.sent = s;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        data_bus = {D3, D2, D1, D0};
        rst_n = 1'b0; valid_a = '0; valid_b = '0; tok_a = 1'b0; tok_b = 1'b0;

        // Single word from src0, then mid-run reset, then src0/src2 alternation.
        tbl[0]  = mk(1, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 8, 0);
        tbl[1]  = mk(0, 4'b0001, 4'b0001, 0, 8'h00, 8'h00, 8, 0);
        tbl[2]  = mk(0, 4'b0000, 4'b0000, 1, 8'hEF, 8'hCD, 7, 0);
        tbl[3]  = mk(0, 4'b0000, 4'b0000, 1, 8'hAB, 8'h89, 7, 0);
        tbl[4]  = mk(0, 4'b0000, 4'b0000, 1, 8'h67, 8'h45, 7, 0);
        tbl[5]  = mk(0, 4'b0000, 4'b0000, 1, 8'h23, 8'h01, 7, 0);
        tbl[6]  = mk(0, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 7, 1);
        tbl[7]  = mk(1, 4'b0101, 4'b0000, 0, 8'h00, 8'h00, 8, 0);
        tbl[8]  = mk(0, 4'b0101, 4'b0001, 0, 8'h00, 8'h00, 8, 0);
        tbl[9]  = mk(0, 4'b0101, 4'b0000, 1, 8'hEF, 8'hCD, 7, 0);
        tbl[10] = mk(0, 4'b0101, 4'b0000, 1, 8'hAB, 8'h89, 7, 0);
        tbl[11] = mk(0, 4'b0101, 4'b0000, 1, 8'h67, 8'h45, 7, 0);
        tbl[12] = mk(0, 4'b0101, 4'b0000, 1, 8'h23, 8'h01, 7, 0);
        tbl[13] = mk(0, 4'b0101, 4'b0100, 0, 8'h00, 8'h00, 7, 1);
        tbl[14] = mk(0, 4'b0101, 4'b0000, 1, 8'h10, 8'h32, 6, 1);
        tbl[15] = mk(0, 4'b0101, 4'b0000, 1, 8'h54, 8'h76, 6, 1);
        tbl[16] = mk(0, 4'b0101, 4'b0000, 1, 8'h98, 8'hBA, 6, 1);
        tbl[17] = mk(0, 4'b0101, 4'b0000, 1, 8'hDC, 8'hFE, 6, 1);
        tbl[18] = mk(0, 4'b0101, 4'b0001, 0, 8'h00, 8'h00, 6, 2);
        tbl[19] = mk(0, 4'b0101, 4'b0000, 1, 8'hEF, 8'hCD, 5, 2);
        tbl[20] = mk(0, 4'b0101, 4'b0000, 1, 8'hAB, 8'h89, 5, 2);
        tbl[21] = mk(0, 4'b0101, 4'b0000, 1, 8'h67, 8'h45, 5, 2);
        tbl[22] = mk(0, 4'b0101, 4'b0000, 1, 8'h23, 8'h01, 5, 2);
        tbl[23] = mk(0, 4'b0101, 4'b0100, 0, 8'h00, 8'h00, 5, 3);
        tbl[24] = mk(0, 4'b0101, 4'b0000, 1, 8'h10, 8'h32, 4, 3);
        tbl[25] = mk(0, 4'b0000, 4'b0000, 1, 8'h54, 8'h76, 4, 3);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            rst_n   = ~tbl[i].rst;
            valid_a = tbl[i].valid;
            #1;
            chk($sformatf("v%0d ready", i),   ready_a, tbl[i].ready);
            chk($sformatf("v%0d valid", i),   v_a,     tbl[i].v);
            chk($sformatf("v%0d ch0", i),     c0_a,    tbl[i].ch0);
            chk($sformatf("v%0d ch1", i),     c1_a,    tbl[i].ch1);
            chk($sformatf("v%0d credits", i), cred_a,  tbl[i].cred);
            chk($sformatf("v%0d sent", i),    sent_a,  tbl[i].sent);
            if (tbl[i].rst) begin
                chk($sformatf("v%0d rst finish", i), fin_a, 7'd0);
                chk($sformatf("v%0d rst err", i),    err_a, 1'b0);
            end
            $display("vec %0d: rst=%0b valid=%b ready=%b v=%0b ch=%h/%h cred=%0d sent=%0d",
                     i, tbl[i].rst, valid_a, ready_a, v_a, c0_a, c1_a, cred_a, sent_a);
        end

        // Token coinciding with an accept, then saturation and sticky token_err.
        @(negedge clk); rst_n = 1'b0; valid_a = '0;
        @(negedge clk); rst_n = 1'b1; valid_a = 4'b0001;
        @(negedge clk); valid_a = '0;
        repeat (4) @(negedge clk);
        #1 chk("tok word A credits", cred_a, 4'd7);
        valid_a = 4'b0001; tok_a = 1'b1;
        #1 chk("tok+accept ready", ready_a, 4'b0001);
        @(negedge clk); valid_a = '0; tok_a = 1'b0;
        #1;
        chk("tok+accept credits", cred_a, 4'd7);
        chk("tok+accept finish", fin_a, 7'd1);
        chk("tok+accept err", err_a, 1'b0);
        chk("tok+accept sending", v_a, 1'b1);
        $display("seq tok+accept: cred=%0d fin=%0d err=%0b", cred_a, fin_a, err_a);
        repeat (4) @(negedge clk);
        tok_a = 1'b1;
        @(negedge clk); tok_a = 1'b0;
        #1;
        chk("tok refill credits", cred_a, 4'd8);
        chk("tok refill finish", fin_a, 7'd2);
        chk("tok refill err", err_a, 1'b0);
        tok_a = 1'b1;
        @(negedge clk); tok_a = 1'b0;
        #1;
        chk("tok sat credits", cred_a, 4'd8);
        chk("tok sat finish", fin_a, 7'd3);
        chk("tok sat err", err_a, 1'b1);
        repeat (3) @(negedge clk);
        #1 chk("tok err sticky", err_a, 1'b1);
        $display("seq tok saturate: cred=%0d fin=%0d err=%0b", cred_a, fin_a, err_a);

        // Asynchronous reset during beat 2, then a clean restart from src1.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; valid_a = 4'b0001;
        @(negedge clk); valid_a = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("arst beat2 valid", v_a, 1'b1);
        chk("arst beat2 ch0", c0_a, 8'h67);
        #2 rst_n = 1'b0;
        #1;
        chk("arst valid low", v_a, 1'b0);
        chk("arst ch0", c0_a, 8'h00);
        chk("arst ch1", c1_a, 8'h00);
        chk("arst credits", cred_a, 4'd8);
        chk("arst sent", sent_a, 7'd0);
        chk("arst err", err_a, 1'b0);
        $display("seq async reset: v=%0b cred=%0d err=%0b", v_a, cred_a, err_a);
        @(negedge clk); rst_n = 1'b1; valid_a = 4'b0010;
        #1 chk("restart ready", ready_a, 4'b0010);
        @(negedge clk); valid_a = '0;
        #1;
        chk("restart beat0 ch0", c0_a, 8'h00);
        chk("restart beat0 ch1", c1_a, 8'h11);
        @(negedge clk);
        #1;
        chk("restart beat1 ch0", c0_a, 8'h22);
        chk("restart beat1 ch1", c1_a, 8'h33);
        $display("seq restart: ch=%h/%h", c0_a, c1_a);

        // Two-credit instance: third word stalls until a token arrives.
        @(negedge clk); valid_b = 4'b0010;
        #1;
        chk("cr2 ready w1", ready_b, 4'b0010);
        chk("cr2 credits w1", cred_b, 4'd2);
        @(negedge clk);
        #1 chk("cr2 credits after w1", cred_b, 4'd1);
        repeat (4) @(negedge clk);
        #1;
        chk("cr2 ready w2", ready_b, 4'b0010);
        chk("cr2 sent before w2", sent_b, 7'd1);
        @(negedge clk);
        #1 chk("cr2 credits after w2", cred_b, 4'd0);
        repeat (4) @(negedge clk);
        #1;
        chk("cr2 stall ready", ready_b, 4'b0000);
        chk("cr2 stall credits", cred_b, 4'd0);
        chk("cr2 stall sent", sent_b, 7'd2);
        chk("cr2 stall valid", v_b, 1'b0);
        @(negedge clk);
        #1 chk("cr2 stall ready 2", ready_b, 4'b0000);
        tok_b = 1'b1;
        #1 chk("cr2 tok cycle ready", ready_b, 4'b0000);
        @(negedge clk); tok_b = 1'b0;
        #1;
        chk("cr2 after tok credits", cred_b, 4'd1);
        chk("cr2 after tok ready", ready_b, 4'b0010);
        chk("cr2 after tok finish", fin_b, 7'd1);
        @(negedge clk); valid_b = '0;
        #1;
        chk("cr2 w3 valid", v_b, 1'b1);
        chk("cr2 w3 credits", cred_b, 4'd0);
        chk("cr2 w3 ch0", c0_b, 8'h00);
        chk("cr2 w3 ch1", c1_b, 8'h11);
        repeat (4) @(negedge clk);
        #1;
        chk("cr2 w3 sent", sent_b, 7'd3);
        chk("cr2 w3 done", v_b, 1'b0);
        $display("seq credits2: cred=%0d sent=%0d fin=%0d", cred_b, sent_b, fin_b);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
